// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the SAP-2 control sequencer.
//   - opcode values of the 10-instruction set (everything else decodes as NOP)
//   - bit positions of the 16-bit control word
//   - T-state encoding (T1..T6, encoded 1..6)
//   - cw_bit(): one-hot control-word mask for a given bit position
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JC  = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CW_PC_EN   = 15;
    localparam int CW_HLT     = 14;
    localparam int CW_MAR_LD  = 13;
    localparam int CW_PC_INC  = 12;
    localparam int CW_RAM_OE  = 11;
    localparam int CW_RAM_WE  = 10;
    localparam int CW_IR_OE   = 9;
    localparam int CW_IR_LD   = 8;
    localparam int CW_A_LD    = 7;
    localparam int CW_A_OE    = 6;
    localparam int CW_ALU_OE  = 5;
    localparam int CW_ALU_SUB = 4;
    localparam int CW_B_LD    = 3;
    localparam int CW_OUT_LD  = 2;
    localparam int CW_PC_LD   = 1;
    localparam int CW_FLAG_LD = 0;

    typedef enum logic [2:0] {
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6
    } t_state_e;

    function automatic logic [15:0] cw_bit(input int idx);
        return 16'd1 << idx;
    endfunction

endpackage

// File: rtl/sap_sequencer_if.sv
// sap_sequencer_if: signals between the sequencer and the IR/flag/datapath side.
//   opcode     : IR upper nibble, stable from T3 to the end of the instruction
//   flag_c     : carry flag (used in T4 of JC)
//   flag_z     : zero flag (used in T4 of JZ)
//   step_mode  : 1 = single-step mode
//   step       : advance qualifier while in single-step mode
//   cw         : 16-bit control word
//   t_state    : current T-state, 1..6
//   instr_done : final T-state of an instruction
//   halt       : registered halt flag
// master = sequencer side, slave = datapath / front-panel side.
interface sap_sequencer_if #(
    parameter int T_W = 3
);
    logic [3:0]     opcode;
    logic           flag_c;
    logic           flag_z;
    logic           step_mode;
    logic           step;
    logic [15:0]    cw;
    logic [T_W-1:0] t_state;
    logic           instr_done;
    logic           halt;

    modport master (
        input  opcode, flag_c, flag_z, step_mode, step,
        output cw, t_state, instr_done, halt
    );

    modport slave (
        output opcode, flag_c, flag_z, step_mode, step,
        input  cw, t_state, instr_done, halt
    );
endinterface

// File: rtl/sap_microcode.sv
// sap_microcode: purely combinational microcode ROM.
//   t_state, opcode, flag_c, flag_z -> cw_raw (ungated control word)
//                                   -> last   (this is the instruction's last active T-state)
// HLT never reports last: the sequencer parks in T4 once halted.
module sap_microcode
    import sap_pkg::*;
(
    input  t_state_e    t_state,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] cw_raw,
    output logic        last
);

    always_comb begin
        cw_raw = '0;
        last   = 1'b0;
        case (t_state)
            T1: cw_raw = cw_bit(CW_PC_EN) | cw_bit(CW_MAR_LD);
            T2: cw_raw = cw_bit(CW_RAM_OE) | cw_bit(CW_IR_LD) | cw_bit(CW_PC_INC);
            T3: cw_raw = '0;
            T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                        cw_raw = cw_bit(CW_IR_OE) | cw_bit(CW_MAR_LD);
                    OP_LDI: begin
                        cw_raw = cw_bit(CW_IR_OE) | cw_bit(CW_A_LD);
                        last   = 1'b1;
                    end
                    OP_JMP: begin
                        cw_raw = cw_bit(CW_IR_OE) | cw_bit(CW_PC_LD);
                        last   = 1'b1;
                    end
                    OP_JC: begin
                        cw_raw = flag_c ? (cw_bit(CW_IR_OE) | cw_bit(CW_PC_LD)) : 16'h0000;
                        last   = 1'b1;
                    end
                    OP_JZ: begin
                        cw_raw = flag_z ? (cw_bit(CW_IR_OE) | cw_bit(CW_PC_LD)) : 16'h0000;
                        last   = 1'b1;
                    end
                    OP_OUT: begin
                        cw_raw = cw_bit(CW_A_OE) | cw_bit(CW_OUT_LD);
                        last   = 1'b1;
                    end
                    OP_HLT:
                        cw_raw = cw_bit(CW_HLT);
                    default:
                        last = 1'b1;   // NOP
                endcase
            end
            T5: begin
                case (opcode)
                    OP_LDA: begin
                        cw_raw = cw_bit(CW_RAM_OE) | cw_bit(CW_A_LD);
                        last   = 1'b1;
                    end
                    OP_ADD, OP_SUB:
                        cw_raw = cw_bit(CW_RAM_OE) | cw_bit(CW_B_LD);
                    OP_STA: begin
                        cw_raw = cw_bit(CW_A_OE) | cw_bit(CW_RAM_WE);
                        last   = 1'b1;
                    end
                    default: cw_raw = '0;
                endcase
            end
            T6: begin
                case (opcode)
                    OP_ADD: begin
                        cw_raw = cw_bit(CW_ALU_OE) | cw_bit(CW_A_LD) | cw_bit(CW_FLAG_LD);
                        last   = 1'b1;
                    end
                    OP_SUB: begin
                        cw_raw = cw_bit(CW_ALU_OE) | cw_bit(CW_ALU_SUB) | cw_bit(CW_A_LD)
                               | cw_bit(CW_FLAG_LD);
                        last   = 1'b1;
                    end
                    default: cw_raw = '0;
                endcase
            end
            default: begin
                cw_raw = '0;
                last   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sap_sequencer.sv
// sap_sequencer: SAP-2 control sequencer.
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset (t_state=1, halt=0, cw forced to 0)
//   bus : sap_sequencer_if.master (opcode/flags/step inputs, cw/t_state/instr_done/halt outputs)
// Parameters:
//   EARLY_END : 1 = return to T1 after the last active T-state, 0 = pad every instruction to T6
//   T_W       : width of t_state
// cw and instr_done are combinational from the registered T-state and the live
// opcode/flag inputs, gated by the advance enable so a stalled or halted
// sequencer never repeats a side-effecting micro-op (PC_INC, RAM_WE, ...).
module sap_sequencer
    import sap_pkg::*;
#(
    parameter bit EARLY_END = 1'b1,
    parameter int T_W       = 3
) (
    input  logic            clk,
    input  logic            rst,
    sap_sequencer_if.master bus
);

    t_state_e    t_reg;
    t_state_e    t_next;
    logic        halt_reg;
    logic        halt_next;
    logic [15:0] cw_raw;
    logic        micro_last;
    logic        adv;
    logic        done_raw;

    sap_microcode u_microcode (
        .t_state (t_reg),
        .opcode  (bus.opcode),
        .flag_c  (bus.flag_c),
        .flag_z  (bus.flag_z),
        .cw_raw  (cw_raw),
        .last    (micro_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_reg    <= T1;
            halt_reg <= 1'b0;
        end else begin
            t_reg    <= t_next;
            halt_reg <= halt_next;
        end
    end

    always_comb begin
        adv       = !halt_reg && (!bus.step_mode || bus.step);
        // In padded mode only T6 ends an instruction; early-finishing
        // instructions simply see zero microcode in the spare T-states.
        done_raw  = EARLY_END ? micro_last : (t_reg == T6);
        t_next    = t_reg;
        halt_next = halt_reg;

        if (adv) begin
            if (t_reg == T4 && bus.opcode == OP_HLT) begin
                halt_next = 1'b1;          // park in T4
            end else if (done_raw || t_reg == T6) begin
                t_next = T1;
            end else begin
                t_next = t_state_e'(t_reg + 3'd1);
            end
        end

        bus.cw         = (adv && !rst) ? cw_raw : 16'h0000;
        bus.instr_done = adv && !rst && done_raw;
    end

    assign bus.t_state = T_W'(t_reg);
    assign bus.halt    = halt_reg;

endmodule

// File: tb/tb_sap_sequencer.sv
module tb_sap_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode1, opcode0;
    logic       flag_c, flag_z, step_mode, step;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    sap_sequencer_if #(.T_W(3)) bus1 ();
    sap_sequencer_if #(.T_W(3)) bus0 ();

    assign bus1.opcode    = opcode1;
    assign bus1.flag_c    = flag_c;
    assign bus1.flag_z    = flag_z;
    assign bus1.step_mode = step_mode;
    assign bus1.step      = step;
    assign bus0.opcode    = opcode0;
    assign bus0.flag_c    = flag_c;
    assign bus0.flag_z    = flag_z;
    assign bus0.step_mode = step_mode;
    assign bus0.step      = step;

    sap_sequencer #(.EARLY_END(1'b1), .T_W(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    sap_sequencer #(.EARLY_END(1'b0), .T_W(3)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%04h required 0x%04h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse released just after a rising edge, so the following cycle is T1.
    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #2;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    // Instruction length in cycles, from the published instruction timings.
    function automatic int ref_len(input logic [3:0] op, input bit ee);
        if (!ee) return 6;
        case (op)
            4'h0, 4'h3: return 5;
            4'h1, 4'h2: return 6;
            default:    return 4;
        endcase
    endfunction

    // Control word for the k-th cycle (1-based) of an instruction.
    function automatic logic [15:0] ref_cw(input logic [3:0] op, input int k,
                                           input logic fc, input logic fz);
        if (k == 1) return 16'hA000;
        if (k == 2) return 16'h1900;
        if (k == 3) return 16'h0000;
        case (op)
            4'h0: return (k == 4) ? 16'h2200 : (k == 5) ? 16'h0880 : 16'h0000;
            4'h1: return (k == 4) ? 16'h2200 : (k == 5) ? 16'h0808 : 16'h00A1;
            4'h2: return (k == 4) ? 16'h2200 : (k == 5) ? 16'h0808 : 16'h00B1;
            4'h3: return (k == 4) ? 16'h2200 : (k == 5) ? 16'h0440 : 16'h0000;
            4'h4: return (k == 4) ? 16'h0280 : 16'h0000;
            4'h5: return (k == 4) ? 16'h0202 : 16'h0000;
            4'h6: return (k == 4 && fc) ? 16'h0202 : 16'h0000;
            4'h7: return (k == 4 && fz) ? 16'h0202 : 16'h0000;
            4'hE: return (k == 4) ? 16'h0044 : 16'h0000;
            4'hF: return (k == 4) ? 16'h4000 : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_check(input string tag, input int k, input bit h,
                               input logic [3:0] op, input bit ee,
                               input logic [15:0] cw_act, input logic [2:0] t_act,
                               input logic done_act, input logic halt_act);
        bit adv;
        adv = !h && (!step_mode || step);
        chk({tag, "_cw"}, cw_act, adv ? ref_cw(op, k, flag_c, flag_z) : 16'h0000);
        chk({tag, "_t"}, 16'(t_act), 16'(k));
        chk({tag, "_done"}, 16'(done_act), 16'(adv && op != 4'hF && k == ref_len(op, ee)));
        chk({tag, "_halt"}, 16'(halt_act), 16'(h));
    endtask

    task automatic model_step(input logic [3:0] op, input bit ee, inout int k, inout bit h);
        if (!h && (!step_mode || step)) begin
            if (op == 4'hF && k == 4) h = 1'b1;
            else if (k == ref_len(op, ee)) k = 1;
            else k = k + 1;
        end
    endtask

    // ---------------- table of whole-instruction vectors (EARLY_END=1) ----------------
    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        fc;
        logic        fz;
        int          n;
        logic [15:0] cw [6];
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [3:0] op, input logic fc,
                                input logic fz, input int n, input logic [15:0] c4,
                                input logic [15:0] c5, input logic [15:0] c6);
        vec_t v;
        v.name  = nm;
        v.op    = op;
        v.fc    = fc;
        v.fz    = fz;
        v.n     = n;
        v.cw[0] = 16'hA000;
        v.cw[1] = 16'h1900;
        v.cw[2] = 16'h0000;
        v.cw[3] = c4;
        v.cw[4] = c5;
        v.cw[5] = c6;
        return v;
    endfunction

    vec_t tbl [12];

    initial begin
        int k1, k0;
        bit h1, h0;
        int instr_cnt;

        tbl[0]  = mk("LDA",   4'h0, 0, 0, 5, 16'h2200, 16'h0880, 16'h0000);
        tbl[1]  = mk("ADD",   4'h1, 0, 0, 6, 16'h2200, 16'h0808, 16'h00A1);
        tbl[2]  = mk("SUB",   4'h2, 0, 0, 6, 16'h2200, 16'h0808, 16'h00B1);
        tbl[3]  = mk("STA",   4'h3, 0, 0, 5, 16'h2200, 16'h0440, 16'h0000);
        tbl[4]  = mk("LDI",   4'h4, 0, 0, 4, 16'h0280, 16'h0000, 16'h0000);
        tbl[5]  = mk("JMP",   4'h5, 0, 0, 4, 16'h0202, 16'h0000, 16'h0000);
        tbl[6]  = mk("JC_c0", 4'h6, 0, 1, 4, 16'h0000, 16'h0000, 16'h0000);
        tbl[7]  = mk("JC_c1", 4'h6, 1, 0, 4, 16'h0202, 16'h0000, 16'h0000);
        tbl[8]  = mk("JZ_z0", 4'h7, 1, 0, 4, 16'h0000, 16'h0000, 16'h0000);
        tbl[9]  = mk("JZ_z1", 4'h7, 0, 1, 4, 16'h0202, 16'h0000, 16'h0000);
        tbl[10] = mk("OUT",   4'hE, 0, 0, 4, 16'h0044, 16'h0000, 16'h0000);
        tbl[11] = mk("NOP",   4'h9, 0, 0, 4, 16'h0000, 16'h0000, 16'h0000);

        rst = 1'b1; opcode1 = 4'h0; opcode0 = 4'h0;
        flag_c = 1'b0; flag_z = 1'b0; step_mode = 1'b0; step = 1'b0;

        // ---- reset state ----
        #12;
        chk("rst_t", 16'(bus1.t_state), 16'd1);
        chk("rst_cw", bus1.cw, 16'h0000);
        chk("rst_done", 16'(bus1.instr_done), 16'd0);
        chk("rst_halt", 16'(bus1.halt), 16'd0);
        chk("rst_cw0", bus0.cw, 16'h0000);
        $display("txn reset: checked reset outputs");
        @(posedge clk);
        #1 rst = 1'b0;

        // ---- table-driven instruction vectors ----
        for (int i = 0; i < 12; i++) begin
            opcode1 = tbl[i].op;
            flag_c  = tbl[i].fc;
            flag_z  = tbl[i].fz;
            for (int k = 0; k < tbl[i].n; k++) begin
                @(negedge clk);
                chk({tbl[i].name, "_t"}, 16'(bus1.t_state), 16'(k + 1));
                chk({tbl[i].name, "_cw"}, bus1.cw, tbl[i].cw[k]);
                chk({tbl[i].name, "_done"}, 16'(bus1.instr_done), 16'(k == tbl[i].n - 1));
                tick();
            end
            $display("txn %s: %0d T-states applied", tbl[i].name, tbl[i].n);
        end
        @(negedge clk);
        chk("after_table_t", 16'(bus1.t_state), 16'd1);

        // ---- HLT: freeze at T4, only reset clears ----
        do_reset();
        opcode1 = 4'hF;
        repeat (3) tick();
        @(negedge clk);
        chk("hlt_t4_cw", bus1.cw, 16'h4000);
        chk("hlt_t4_halt", 16'(bus1.halt), 16'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hlt_frozen_t", 16'(bus1.t_state), 16'd4);
            chk("hlt_frozen_cw", bus1.cw, 16'h0000);
            chk("hlt_frozen_halt", 16'(bus1.halt), 16'd1);
            tick();
        end
        do_reset();
        @(negedge clk);
        chk("hlt_rst_t", 16'(bus1.t_state), 16'd1);
        chk("hlt_rst_halt", 16'(bus1.halt), 16'd0);
        $display("txn HLT: halted 10 cycles then reset");

        // ---- single step ----
        do_reset();
        opcode1 = 4'h0; step_mode = 1'b1; step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_t", 16'(bus1.t_state), 16'd1);
            chk("stall_cw", bus1.cw, 16'h0000);
            tick();
        end
        step = 1'b1;
        @(negedge clk);
        chk("step1_cw", bus1.cw, 16'hA000);
        tick();
        step = 1'b0;
        @(negedge clk);
        chk("step1_t", 16'(bus1.t_state), 16'd2);
        chk("step1_hold_cw", bus1.cw, 16'h0000);
        tick();
        step = 1'b1;
        @(negedge clk);
        chk("step2_cw", bus1.cw, 16'h1900);
        tick();
        step = 1'b0; step_mode = 1'b0;
        @(negedge clk);
        chk("step2_t", 16'(bus1.t_state), 16'd3);
        $display("txn STEP: single-step advances checked");

        // ---- EARLY_END=0 with LDA ----
        do_reset();
        opcode0 = 4'h0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("pad_lda_t", 16'(bus0.t_state), 16'(k));
            chk("pad_lda_cw", bus0.cw, ref_cw(4'h0, k, 1'b0, 1'b0));
            chk("pad_lda_done", 16'(bus0.instr_done), 16'(k == 6));
            tick();
        end
        @(negedge clk);
        chk("pad_lda_wrap_t", 16'(bus0.t_state), 16'd1);
        $display("txn PAD_LDA: six T-states checked");

        // ---- reset during T5 of ADD ----
        do_reset();
        opcode1 = 4'h1;
        repeat (4) tick();
        @(negedge clk);
        chk("add_t5_cw", bus1.cw, 16'h0808);
        #1 rst = 1'b1;
        #1;
        chk("midrst_t", 16'(bus1.t_state), 16'd1);
        chk("midrst_cw", bus1.cw, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_rel_t", 16'(bus1.t_state), 16'd1);
        chk("midrst_rel_cw", bus1.cw, 16'hA000);
        tick();
        @(negedge clk);
        chk("midrst_no_t6", 16'(bus1.t_state), 16'd2);
        $display("txn MIDRST: ADD aborted in T5");

        // ---- randomized run against the reference model ----
        do_reset();
        k1 = 1; k0 = 1; h1 = 1'b0; h0 = 1'b0; instr_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            if (k1 == 1) opcode1 = 4'($urandom_range(0, 14));
            if (k0 == 1) opcode0 = 4'($urandom_range(0, 14));
            step_mode = ($urandom_range(0, 3) == 0);
            step      = 1'($urandom_range(0, 1));
            flag_c    = 1'($urandom_range(0, 1));
            flag_z    = 1'($urandom_range(0, 1));
            @(negedge clk);
            model_check("rnd1", k1, h1, opcode1, 1'b1, bus1.cw, bus1.t_state,
                        bus1.instr_done, bus1.halt);
            model_check("rnd0", k0, h0, opcode0, 1'b0, bus0.cw, bus0.t_state,
                        bus0.instr_done, bus0.halt);
            if (bus1.instr_done) instr_cnt++;
            @(posedge clk);
            model_step(opcode1, 1'b1, k1, h1);
            model_step(opcode0, 1'b0, k0, h0);
            #1;
        end
        $display("txn RANDOM: 2000 cycles, %0d instructions completed on early-end unit", instr_cnt);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sap_sequencer.md
# sap_sequencer

Parametrised SAP-2-class control sequencer replacing the fixed six-T-state SAP-1 controller. It decodes a 10-instruction set (adds STA, LDI, JMP, JC, JZ) into a 16-bit control word. Instructions terminate early after their last useful T-state, and a single-step mode supports front-panel debugging. It sits between the instruction register/flag register and every bus-attached datapath block.

## Interface
- `EARLY_END`, default 1: 1 returns to T1 after an instruction's last active T-state; 0 pads every instruction to T6 with zero control words (SAP-1 compatible timing).
- `T_W`, default 3: width of the `t_state` output.
- Reset is `rst`: asynchronous, active-high. The clock is `clk`.
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `opcode`, input, 4: upper nibble of IR; stable from T3 through the end of the instruction.
- `flag_c`, input, 1: carry flag, sampled combinationally in T4 of JC.
- `flag_z`, input, 1: zero flag, sampled combinationally in T4 of JZ.
- `step_mode`, input, 1: 1 selects single-step mode.
- `step`, input, 1: advance qualifier in single-step mode; one T-state per cycle while high.
- `cw`, output, 16: control word.
- `t_state`, output, T_W: current T-state, encoded 1..6.
- `instr_done`, output, 1: high during the final T-state of an instruction.
- `halt`, output, 1: registered halt flag.

## Operation
- `cw` bit map: 15 PC_EN, 14 HLT, 13 MAR_LD, 12 PC_INC, 11 RAM_OE, 10 RAM_WE, 9 IR_OE, 8 IR_LD, 7 A_LD, 6 A_OE, 5 ALU_OE, 4 ALU_SUB, 3 B_LD, 2 OUT_LD, 1 PC_LD, 0 FLAG_LD.
- Opcodes: LDA=0, ADD=1, SUB=2, STA=3, LDI=4, JMP=5, JC=6, JZ=7, OUT=E, HLT=F. All other opcodes are NOPs.
- Fetch:
  - T1: PC_EN|MAR_LD.
  - T2: RAM_OE|IR_LD|PC_INC.
  - T3: 0 (decode).
- LDA: T4 IR_OE|MAR_LD; T5 RAM_OE|A_LD, last.
- ADD: T4 IR_OE|MAR_LD; T5 RAM_OE|B_LD; T6 ALU_OE|A_LD|FLAG_LD, last.
- SUB: same as ADD, with ALU_SUB also set in T6.
- STA: T4 IR_OE|MAR_LD; T5 A_OE|RAM_WE, last.
- LDI: T4 IR_OE|A_LD, last.
- JMP: T4 IR_OE|PC_LD, last.
- JC: T4 IR_OE|PC_LD if flag_c=1, otherwise 0; last either way.
- JZ: same as JC, using flag_z.
- OUT: T4 A_OE|OUT_LD, last.
- NOP: T4 0, last.
- HLT: T4 HLT; halt is set at the end of that cycle.
- EARLY_END=0: instructions that finish early continue to T6 with cw=0. `instr_done` is then asserted only at T6.
- Advance enable `adv` = !halt & (!step_mode | step).
  - `t_state` changes only when adv=1.
  - `cw` = microcode & {16{adv}}, so a stalled or halted sequencer drives cw=0. This prevents repeated PC_INC or RAM_WE.
  - `instr_done` is gated by adv in the same way.
- Halt: `t_state` freezes at T4 and cw=0 thereafter. Only `rst` clears halt.

## Timing
- Reset values: t_state=1, halt=0, cw=0, instr_done=0. cw is forced to 0 while rst is high.
- Reset mid-instruction aborts immediately. The first cycle after release is T1 with cw=0xA000.
- `cw` and `instr_done` are combinational from registered t_state and live opcode/flag inputs. There is zero latency within the T-state.
- Instruction length with EARLY_END=1:
  - 4 cycles: LDI, JMP, JC, JZ, OUT, NOP.
  - 5 cycles: LDA, STA.
  - 6 cycles: ADD, SUB.
- Instruction length with EARLY_END=0: 6 cycles for every instruction.
- If step_mode toggles mid-instruction, it takes effect the same cycle. No T-state is lost or duplicated.
- A flag change during T4 of JC/JZ is seen in the same cycle. Flags are don't-care in every other T-state.

## Structure
- Package `sap_pkg`: opcode localparams, cw bit-index localparams, T-state encodings (T1..T6).
- Sub-module `sap_microcode`: purely combinational (t_state, opcode, flag_c, flag_z) -> raw cw and last-T-state indication.
- Top level: T-state register, halt register, adv gating, EARLY_END padding.

## Test plan
- Reset, free run with LDA and EARLY_END=1 -> t_state 1,2,3,4,5,1; cw 0xA000, 0x1900, 0x0000, 0x2200, 0x0880; instr_done only at T5.
- SUB -> T5 cw 0x0808, T6 cw 0x00B1; STA -> T5 cw 0x0440.
- JC: flag_c=0 -> T4 cw 0x0000; flag_c=1 -> T4 cw 0x0202. Both return to T1 next cycle.
- HLT -> T4 cw 0x4000, halt=1 the following cycle, t_state stays 4, cw 0 for 10 cycles; rst -> t_state 1, halt 0.
- step_mode=1 with step low for 5 cycles -> t_state frozen and cw 0; one-cycle step pulse -> exactly one advance with that T-state's cw.
- EARLY_END=0 with LDA -> six T-states, T6 cw 0, instr_done at T6. rst asserted during T5 of ADD -> no T6, cw 0xA000 after release.
